// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of the RV32E core. Owns the PC and is the only master of the
// combinational program ROM. Each fetched word is captured together with its
// PC into a small FIFO and handed to decode over a valid/ready handshake.
// Redirects from execute flush the FIFO and reload the PC. A misaligned
// redirect target parks the stage in a fault state until an aligned redirect
// arrives.
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   rom_addr       out  32  ROM byte address (always the PC register)
//   rom_data       in   32  ROM word for rom_addr, same cycle
//   instr_valid    out  1   FIFO head holds a valid instruction
//   instr          out  32  instruction at FIFO head (0 when empty)
//   instr_pc       out  32  PC of instr (0 when empty)
//   instr_ready    in   1   decode accepts the head this cycle
//   redirect_valid in   1   load redirect_pc into the PC this cycle
//   redirect_pc    in   32  redirect target byte address
//   fetch_fault    out  1   misaligned-target fault state active
//   fault_pc       out  32  last misaligned target (0 if none yet)
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    state_e           state_q,    state_d;
    logic [31:0]      pc_q,       pc_d;
    logic [31:0]      fault_pc_q, fault_pc_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;

    logic [31:0] mem_instr_q [DEPTH];
    logic [31:0] mem_pc_q    [DEPTH];

    logic push_s;
    logic pop_s;

    // A redirect cancels both sides of the FIFO: nothing is captured and any
    // handshake in that cycle is void for decode as well.
    assign push_s = (state_q == ST_RUN) && (count_q < DEPTH_C) && !redirect_valid;
    assign pop_s  = instr_valid && instr_ready && !redirect_valid;

    assign rom_addr    = pc_q;
    assign instr_valid = (count_q != {CNT_W{1'b0}});
    assign instr       = instr_valid ? mem_instr_q[rd_ptr_q] : 32'h0000_0000;
    assign instr_pc    = instr_valid ? mem_pc_q[rd_ptr_q]    : 32'h0000_0000;
    assign fetch_fault = (state_q == ST_FAULT);
    assign fault_pc    = fault_pc_q;

    // Next-state logic: PC, fault state, FIFO pointers and occupancy.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (redirect_valid) begin
            count_d  = {CNT_W{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            wr_ptr_d = {AW{1'b0}};
            // The PC is always kept word aligned; a misaligned target is
            // remembered in fault_pc instead.
            pc_d     = {redirect_pc[31:2], 2'b00};
            if (redirect_pc[1:0] == 2'b00) begin
                state_d = ST_RUN;
            end else begin
                state_d    = ST_FAULT;
                fault_pc_d = redirect_pc;
            end
        end else begin
            if (push_s) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                pc_d     = pc_q;
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            fault_pc_q <= 32'h0000_0000;
            count_q    <= {CNT_W{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO storage: captures the ROM word and its PC at the tail on a push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= 32'h0000_0000;
                mem_pc_q[i]    <= 32'h0000_0000;
            end
        end else if (push_s) begin
            mem_instr_q[wr_ptr_q] <= rom_data;
            mem_pc_q[wr_ptr_q]    <= pc_q;
        end
    end

endmodule
